// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered frame store.
// Build option FB_RD_OUTREG_EN (see fb_pingpong) adds a read output register stage.
package fb_pkg;
  localparam int CH_W_DEF   = 8;
  localparam int NUM_CH_DEF = 3;

  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;

  localparam int OVR_CNT_W = 8;

  typedef logic [NUM_CH_DEF*CH_W_DEF-1:0] pixel_t;
endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM, per-channel write enables, registered read.
// Out-of-range writes are dropped and out-of-range reads return zero.
module fb_bank
  import fb_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 10000,
  parameter int ADDR_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_CH*CH_W-1:0]   wr_data,
  input  logic [NUM_CH-1:0]        wr_be,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [NUM_CH*CH_W-1:0]   rd_data
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic [NUM_CH*CH_W-1:0] mem [DEPTH];
  logic                   wr_ok;
  logic                   rd_ok;

  // Full-width compare so addresses aliasing into the index range are rejected
  assign wr_ok = wr_en && ({1'b0, wr_addr} < LIMIT);
  assign rd_ok = {1'b0, rd_addr} < LIMIT;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_be[k]) begin
          mem[wr_addr[IDX_W-1:0]][k*CH_W +: CH_W] <= wr_data[k*CH_W +: CH_W];
        end
      end
    end
  end

  // p0: registered read data, cleared by reset so the output pixel starts at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_ok ? mem[rd_addr[IDX_W-1:0]] : '0;
    end
  end
endmodule

// File: rtl/fb_pingpong.sv
// Double-buffered pixel frame store with frame-boundary bank swap and overrun count.
// Optional FB_RD_OUTREG_EN: extra output register, read latency 2 instead of 1.
module fb_pingpong
  import fb_pkg::*;
#(
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3,
  parameter int DEPTH  = 10000,
  parameter int ADDR_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_CH*CH_W-1:0]   wr_data,
  input  logic [NUM_CH-1:0]        wr_be,
  input  logic                     wr_frame_done,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_frame_start,
  output logic [NUM_CH*CH_W-1:0]   rd_pix,
  output logic                     rd_valid,
  output logic                     bank_wr,
  output logic                     swap_pending,
  output logic [OVR_CNT_W-1:0]     overrun_cnt
);
  logic [NUM_CH*CH_W-1:0] rd_data0;
  logic [NUM_CH*CH_W-1:0] rd_data1;
  logic [NUM_CH*CH_W-1:0] pix_p0;
  logic                   vld_p0;
  logic                   sel_p0;
  logic                   swap;

  function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  fb_bank #(.CH_W(CH_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && !bank_wr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .rd_en   (rd_en && bank_wr),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  fb_bank #(.CH_W(CH_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && bank_wr),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .rd_en   (rd_en && !bank_wr),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

  // p0: remember which bank served the read, so a swap cannot redirect it
  always_ff @(posedge clk) begin
    if (rd_en) sel_p0 <= ~bank_wr;
  end

  always_ff @(posedge clk) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= rd_en;
  end

  assign pix_p0 = sel_p0 ? rd_data1 : rd_data0;

`ifdef FB_RD_OUTREG_EN
  logic [NUM_CH*CH_W-1:0] pix_p1;
  logic                   vld_p1;

  // p1: optional output stage; holds the last pixel between reads
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) pix_p1 <= pix_p0;
    end
  end

  assign rd_pix   = pix_p1;
  assign rd_valid = vld_p1;
`else
  assign rd_pix   = pix_p0;
  assign rd_valid = vld_p0;
`endif

  assign swap = rd_frame_start && swap_pending;

  // A frame completed while one is already pending overwrote it before display
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_wr      <= 1'b0;
      swap_pending <= 1'b0;
      overrun_cnt  <= '0;
    end else begin
      if (swap) bank_wr <= ~bank_wr;
      if (wr_frame_done && swap_pending) overrun_cnt <= sat_inc(overrun_cnt);
      if (wr_frame_done) swap_pending <= !swap;
      else if (swap)     swap_pending <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fb_pingpong.sv
// Scoreboard bench for fb_pingpong: reads push expected pixels, the output monitor pops them.
// Honours FB_RD_OUTREG_EN for the expected read latency.
module tb_fb_pingpong;
  import fb_pkg::*;

  localparam int CH_W   = 8;
  localparam int NUM_CH = 3;
  localparam int DEPTH  = 12;
  localparam int ADDR_W = 5;
`ifdef FB_RD_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  pixel_t            wr_data = '0;
  logic [NUM_CH-1:0] wr_be = '0;
  logic              wr_frame_done = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_frame_start = 1'b0;
  pixel_t            rd_pix;
  logic              rd_valid;
  logic              bank_wr;
  logic              swap_pending;
  logic [7:0]        overrun_cnt;

  fb_pingpong #(.CH_W(CH_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_be          (wr_be),
    .wr_frame_done  (wr_frame_done),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_frame_start (rd_frame_start),
    .rd_pix         (rd_pix),
    .rd_valid       (rd_valid),
    .bank_wr        (bank_wr),
    .swap_pending   (swap_pending),
    .overrun_cnt    (overrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference state
  pixel_t m_mem[2][DEPTH];
  bit     m_known[2][DEPTH];
  bit     m_bw   = 1'b0;
  bit     m_pend = 1'b0;
  int     m_ovr  = 0;
  pixel_t last_exp = '0;

  typedef struct {
    pixel_t d;
    int     due;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic pixel_t mkpix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pixel_t p;
    p = '0;
    p[CH_R*CH_W +: CH_W] = r;
    p[CH_G*CH_W +: CH_W] = g;
    p[CH_B*CH_W +: CH_W] = b;
    return p;
  endfunction

  // Output monitor: every rd_valid must match the oldest expected read, on time
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid) begin
      if (sbq.size() == 0) begin
        chk("spurious_rd_valid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("rd_pix", rd_pix, e.d);
        chk("rd_latency", cyc, e.due);
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("missing_rd_valid", 32'd0, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input pixel_t d, input logic [NUM_CH-1:0] be);
    int b;
    b = m_bw ? 1 : 0;
    wr_en = 1'b1; wr_addr = a[ADDR_W-1:0]; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
    if (a < DEPTH) begin
      for (int k = 0; k < NUM_CH; k++)
        if (be[k]) m_mem[b][a][k*CH_W +: CH_W] = d[k*CH_W +: CH_W];
      if (be == '1) m_known[b][a] = 1'b1;
    end
  endtask

  // Drive a read for the coming edge and record what it must return
  task automatic rd_set(input int a, input bit use_exp, input pixel_t exp);
    exp_t e;
    int   rb;
    rb = m_bw ? 0 : 1;
    rd_en = 1'b1; rd_addr = a[ADDR_W-1:0];
    e.due = cyc + LAT;
    if (use_exp)       e.d = exp;
    else if (a >= DEPTH) e.d = '0;
    else               e.d = m_mem[rb][a];
    last_exp = e.d;
    sbq.push_back(e);
  endtask

  task automatic rd(input int a);
    rd_set(a, 1'b0, '0);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic rd_exp(input int a, input pixel_t exp);
    rd_set(a, 1'b1, exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic rd_burst();
    for (int a = 0; a < DEPTH; a++) begin
      rd_set(a, 1'b0, '0);
      tick();
    end
    rd_en = 1'b0;
  endtask

  task automatic frame(input bit wfd, input bit rfs);
    bit p;
    p = m_pend;
    wr_frame_done = wfd; rd_frame_start = rfs;
    tick();
    wr_frame_done = 1'b0; rd_frame_start = 1'b0;
    if (rfs && p) m_bw = !m_bw;
    if (wfd && p && m_ovr < 255) m_ovr++;
    if (wfd)           m_pend = !(rfs && p);
    else if (rfs && p) m_pend = 1'b0;
    chk("bank_wr", bank_wr, m_bw);
    chk("swap_pending", swap_pending, m_pend);
    chk("overrun_cnt", overrun_cnt, m_ovr);
  endtask

  task automatic do_reset();
    sbq.delete();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    m_bw = 1'b0; m_pend = 1'b0; m_ovr = 0;
    chk("rst_rd_pix", rd_pix, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_bank_wr", bank_wr, 0);
    chk("rst_swap_pending", swap_pending, 0);
    chk("rst_overrun_cnt", overrun_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Basic write, handover and read
    wr(5, mkpix(8'h11, 8'h22, 8'h33), 3'b111);
    frame(1'b1, 1'b0);
    chk("no_swap_before_vsync", bank_wr, 0);
    frame(1'b0, 1'b1);
    chk("bank_wr_after_swap", bank_wr, 1);
    rd_exp(5, 24'h112233);

    // Writes to the other bank stay invisible until a swap
    wr(5, mkpix(8'h44, 8'h55, 8'h66), 3'b111);
    rd_exp(5, 24'h112233);

    // Coincident pulses: pending clear sets pending only, pending set swaps and counts
    frame(1'b1, 1'b1);
    chk("coinc_p0_bank", bank_wr, 1);
    chk("coinc_p0_pend", swap_pending, 1);
    frame(1'b1, 1'b1);
    chk("coinc_p1_bank", bank_wr, 0);
    chk("coinc_p1_pend", swap_pending, 0);
    chk("coinc_p1_ovr", overrun_cnt, 1);
    rd_exp(5, 24'h445566);

    // Green-only write over 0x112233
    wr(5, mkpix(8'hAA, 8'hBB, 8'hCC), 3'b010);
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b1);
    rd_exp(5, 24'h11BB33);

    // Fill the write bank, with out-of-range and aliasing writes mixed in
    for (int a = 0; a < DEPTH; a++) wr(a, pixel_t'($urandom), 3'b111);
    wr(DEPTH, 24'hDEAD01, 3'b111);
    wr(5 + 16, 24'hDEAD02, 3'b111);
    wr(31, 24'hDEAD03, 3'b111);
    frame(1'b1, 1'b0);
    // Read in flight across the swap still comes from the old bank
    rd_set(5, 1'b1, 24'h11BB33);
    frame(1'b0, 1'b1);
    rd_en = 1'b0;
    rd(DEPTH);
    rd(31);
    rd_burst();
    repeat (LAT + 2) tick();
    chk("rd_valid_idle", rd_valid, 0);
    chk("rd_pix_hold", rd_pix, last_exp);

    // Fill the other bank, then random partial overwrites
    for (int a = 0; a < DEPTH; a++) wr(a, pixel_t'($urandom), 3'b111);
    for (int i = 0; i < 20; i++)
      wr($urandom_range(0, DEPTH - 1), pixel_t'($urandom), 3'($urandom_range(0, 7)));
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b1);
    rd_burst();

    // Mid-frame reset discards pending swap and the in-flight read, keeps memory
    frame(1'b1, 1'b0);
    rd_en = 1'b1; rd_addr = 5;
    reset = 1'b1;
    tick();
    rd_en = 1'b0;
    do_reset();
    rd_burst();

    // Overrun accounting and saturation
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    chk("ovr_first", overrun_cnt, 1);
    chk("ovr_pending", swap_pending, 1);
    repeat (300) frame(1'b1, 1'b0);
    chk("ovr_saturated", overrun_cnt, 255);
    frame(1'b1, 1'b1);
    chk("ovr_sat_swap", overrun_cnt, 255);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sbq.size() > 0; i++) tick();
    chk("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_pingpong.md
# fb_pingpong

Parametrised double-buffered pixel frame store for the display adapter. The pixel writer fills one bank while the scan-out reader drains the other. Completed frames are handed over only at a reader frame boundary, so scan-out never tears. It replaces the single-bank RGB buffer and adds per-channel write enables, the bank-swap handshake and overrun accounting.

## Interface
- CH_W, 8: bits per colour channel
- NUM_CH, 3: channels per pixel; channel 0 = B, 1 = G, 2 = R, packed LSB-first
- DEPTH, 10000: pixels per bank
- ADDR_W, 20: address width; must satisfy 2^ADDR_W >= DEPTH
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe into the write bank
- wr_addr  in  ADDR_W  write pixel address
- wr_data  in  NUM_CH*CH_W  packed write pixel
- wr_be  in  NUM_CH  per-channel write enable
- wr_frame_done  in  1  one-cycle pulse: write bank holds a complete frame
- rd_en  in  1  read strobe from the read bank
- rd_addr  in  ADDR_W  read pixel address
- rd_frame_start  in  1  one-cycle pulse at the reader's frame start (vsync)
- rd_pix  out  NUM_CH*CH_W  packed read pixel
- rd_valid  out  1  rd_pix holds data for a completed read
- bank_wr  out  1  index of the current write bank; the read bank is ~bank_wr
- swap_pending  out  1  a completed frame is waiting for the next rd_frame_start
- overrun_cnt  out  8  saturating count of frames overwritten before display

## Operation
- Two banks of DEPTH x (NUM_CH*CH_W) bits each. Memory contents are not reset.
- Write path:
  - wr_en=1 and wr_addr < DEPTH: write channel k of bank[bank_wr][wr_addr] only where wr_be[k]=1.
  - wr_addr >= DEPTH: the write is dropped silently.
- Read path:
  - rd_en=1: read bank[~bank_wr][rd_addr].
  - rd_addr >= DEPTH returns all zeros with rd_valid still asserted.
- A read and a write in the same cycle are always legal, because they target different banks.
- Swap state (swap_pending), evaluated each cycle on the registered pending value P:
  - rd_frame_start=1 and P=1: toggle bank_wr and clear pending.
  - wr_frame_done=1 and P=1: increment overrun_cnt, saturating at 255. The pending bank was overwritten.
  - wr_frame_done=1 and rd_frame_start=0: set pending.
  - wr_frame_done=1 and rd_frame_start=1 and P=0: set pending. The swap occurs at the next rd_frame_start.
  - wr_frame_done=1 and rd_frame_start=1 and P=1: swap, count the overrun, leave pending clear.
  - rd_frame_start=1 and P=0: no swap; the reader repeats the old frame.
- A bank swap does not affect a read already in flight; its data comes from the pre-swap read bank.

## Timing
- Reset values: rd_pix=0, rd_valid=0, bank_wr=0, swap_pending=0, overrun_cnt=0.
- Reset asserted mid-frame discards any pending swap and in-flight reads; memory is left untouched.
- Read latency:
  - 1 cycle: rd_en at edge N gives rd_pix/rd_valid after edge N+1.
  - rd_valid is high for exactly one cycle per rd_en.
  - rd_pix holds its last value when rd_valid=0.
- Writes are visible to the reader only after a swap. Earliest visibility: the read issued in the cycle after the swapping rd_frame_start.
- bank_wr and swap_pending update at the edge that samples the pulse.
- Back-to-back rd_en sustains one pixel per clock.

## Configuration
- FB_RD_OUTREG_EN:
  - Defined: adds a second output register stage on rd_pix/rd_valid. Read latency becomes 2 cycles; throughput is unchanged; reset clears both stages.
  - Undefined: 1-cycle latency as above.

## Structure
- fb_pkg holds:
  - the pixel typedef
  - channel index constants CH_B=0, CH_G=1, CH_R=2
  - OVR_CNT_W=8
- Sub-module fb_bank: simple dual-port RAM with per-channel write enable and registered read. Instantiated twice; the top level holds the swap logic and the read mux.

## Test plan
- Reset, write 0x112233 to addr 5 (all wr_be), wr_frame_done, rd_frame_start, read addr 5 -> rd_pix=0x112233 with rd_valid one cycle after rd_en; bank_wr=1.
- Before any swap, read addr 5 after writing it -> data is the prior read-bank content, not 0x112233.
- wr_be=3'b010, wr_data=0xAABBCC over existing 0x112233, then swap -> read returns 0x11BB33.
- Two wr_frame_done pulses with no rd_frame_start -> overrun_cnt=1, swap_pending=1. 300 such pulses -> overrun_cnt saturates at 255.
- wr_frame_done and rd_frame_start in the same cycle:
  - with pending=0 -> no swap that cycle, swap_pending=1.
  - with pending=1 -> bank_wr toggles, swap_pending=0, overrun_cnt increments.
- Write to addr DEPTH, then read addr DEPTH -> memory unchanged, rd_pix=0, rd_valid=1. With FB_RD_OUTREG_EN defined, rd_valid arrives 2 cycles after rd_en.
